axil_ram_slave: RTL and testbench



---
 rtl/axil_ram_slave.sv | 163 ++++++++++++++++
 tb/tb_axil_ram_slave.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_ram_slave.sv
// AXI4-Lite slave terminating on an internal word RAM with byte-strobed writes.
// Optional: define AXIL_RAM_SLAVE_RANGE_CHECK_EN to answer SLVERR for addresses beyond the RAM.
module axil_ram_slave #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_awaddr,
  input  logic [2:0]                    S_AXI_awprot,
  input  logic                          S_AXI_awvalid,
  output logic                          S_AXI_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     S_AXI_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   S_AXI_wstrb,
  input  logic                          S_AXI_wvalid,
  output logic                          S_AXI_wready,
  output logic [1:0]                    S_AXI_bresp,
  output logic                          S_AXI_bvalid,
  input  logic                          S_AXI_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_araddr,
  input  logic [2:0]                    S_AXI_arprot,
  input  logic                          S_AXI_arvalid,
  output logic                          S_AXI_arready,
  output logic [AXI_DATA_WIDTH-1:0]     S_AXI_rdata,
  output logic [1:0]                    S_AXI_rresp,
  output logic                          S_AXI_rvalid,
  input  logic                          S_AXI_rready
);

  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int MEM_DEPTH  = 1 << MEM_ADDR_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                      init_done_reg;
  logic                      aw_held_reg;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_reg;
  logic                      w_held_reg;
  logic [AXI_DATA_WIDTH-1:0] w_data_reg;
  logic [STRB_WIDTH-1:0]     w_strb_reg;
  logic                      bvalid_reg;
  logic [1:0]                bresp_reg;
  logic                      rvalid_reg;
  logic [1:0]                rresp_reg;
  logic [AXI_DATA_WIDTH-1:0] rdata_reg;

  logic                      aw_hs;
  logic                      w_hs;
  logic                      ar_hs;
  logic                      commit;
  logic                      wr_en;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0]     wr_strb;
  logic [MEM_ADDR_WIDTH-1:0] wr_index;
  logic [MEM_ADDR_WIDTH-1:0] rd_index;
  logic                      wr_oor;
  logic                      rd_oor;
  logic                      unused_bits;

  // Readies stay low for the first edge after reset release via init_done_reg.
  assign S_AXI_awready = init_done_reg && !aw_held_reg && !bvalid_reg;
  assign S_AXI_wready  = init_done_reg && !w_held_reg && !bvalid_reg;
  assign S_AXI_arready = init_done_reg && !rvalid_reg;
  assign S_AXI_bvalid  = bvalid_reg;
  assign S_AXI_bresp   = bresp_reg;
  assign S_AXI_rvalid  = rvalid_reg;
  assign S_AXI_rresp   = rresp_reg;
  assign S_AXI_rdata   = rdata_reg;

  assign aw_hs = S_AXI_awvalid && S_AXI_awready;
  assign w_hs  = S_AXI_wvalid && S_AXI_wready;
  assign ar_hs = S_AXI_arvalid && S_AXI_arready;

  // A held half pairs with a live handshake of the other half, so no extra cycle is spent.
  always_comb begin
    wr_addr  = aw_held_reg ? aw_addr_reg : S_AXI_awaddr;
    wr_data  = w_held_reg  ? w_data_reg  : S_AXI_wdata;
    wr_strb  = w_held_reg  ? w_strb_reg  : S_AXI_wstrb;
    commit   = (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
    wr_index = wr_addr[ADDR_LSB +: MEM_ADDR_WIDTH];
    rd_index = S_AXI_araddr[ADDR_LSB +: MEM_ADDR_WIDTH];
    wr_en    = commit && !wr_oor;
  end

`ifdef AXIL_RAM_SLAVE_RANGE_CHECK_EN
  assign wr_oor = (wr_addr >> (MEM_ADDR_WIDTH + ADDR_LSB)) != '0;
  assign rd_oor = (S_AXI_araddr >> (MEM_ADDR_WIDTH + ADDR_LSB)) != '0;
`else
  // Upper address bits are dropped, so accesses alias into the RAM.
  assign wr_oor = 1'b0;
  assign rd_oor = 1'b0;
`endif

  assign unused_bits = ^{S_AXI_awprot, S_AXI_arprot, wr_addr, S_AXI_araddr};

  // RAM write port: no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wr_strb[b]) begin
          mem[wr_index][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Write channel holding registers and response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_done_reg <= 1'b0;
      aw_held_reg   <= 1'b0;
      aw_addr_reg   <= '0;
      w_held_reg    <= 1'b0;
      w_data_reg    <= '0;
      w_strb_reg    <= '0;
      bvalid_reg    <= 1'b0;
      bresp_reg     <= RESP_OKAY;
    end else begin
      init_done_reg <= 1'b1;
      if (commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= wr_oor ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (aw_hs) begin
          aw_held_reg <= 1'b1;
          aw_addr_reg <= S_AXI_awaddr;
        end
        if (w_hs) begin
          w_held_reg <= 1'b1;
          w_data_reg <= S_AXI_wdata;
          w_strb_reg <= S_AXI_wstrb;
        end
        if (bvalid_reg && S_AXI_bready) begin
          bvalid_reg <= 1'b0;
        end
      end
    end
  end

  // Read channel: synchronous RAM read straight into the response register.
  // A same-edge write lands after this read, giving read-before-write ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_reg <= 1'b0;
      rresp_reg  <= RESP_OKAY;
      rdata_reg  <= '0;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rresp_reg  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
      rdata_reg  <= rd_oor ? '0 : mem[rd_index];
    end else if (rvalid_reg && S_AXI_rready) begin
      rvalid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_ram_slave.sv
// Self-checking bench for axil_ram_slave: vector table, hand-written corner sequences,
// and randomized traffic against a word-array reference model.
module tb_axil_ram_slave;

`ifdef AXIL_RAM_SLAVE_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] SLVERR   = 2'b10;
  localparam logic [1:0] OOR_RESP = RANGE_CHK ? SLVERR : OKAY;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] S_AXI_awaddr;
  logic [2:0]  S_AXI_awprot;
  logic        S_AXI_awvalid;
  logic        S_AXI_awready;
  logic [31:0] S_AXI_wdata;
  logic [3:0]  S_AXI_wstrb;
  logic        S_AXI_wvalid;
  logic        S_AXI_wready;
  logic [1:0]  S_AXI_bresp;
  logic        S_AXI_bvalid;
  logic        S_AXI_bready;
  logic [31:0] S_AXI_araddr;
  logic [2:0]  S_AXI_arprot;
  logic        S_AXI_arvalid;
  logic        S_AXI_arready;
  logic [31:0] S_AXI_rdata;
  logic [1:0]  S_AXI_rresp;
  logic        S_AXI_rvalid;
  logic        S_AXI_rready;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  axil_ram_slave #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .MEM_ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awprot(S_AXI_awprot), .S_AXI_awvalid(S_AXI_awvalid),
    .S_AXI_awready(S_AXI_awready), .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb),
    .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready), .S_AXI_bresp(S_AXI_bresp),
    .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready), .S_AXI_araddr(S_AXI_araddr),
    .S_AXI_arprot(S_AXI_arprot), .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
    .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp), .S_AXI_rvalid(S_AXI_rvalid),
    .S_AXI_rready(S_AXI_rready)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[13];
  logic [31:0] model[1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // All transaction tasks start and end just after a rising edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output bit ok);
    bit aw_done, w_done, hs_aw, hs_w, got;
    aw_done = 0; w_done = 0; got = 0; ok = 1; resp = 2'bxx;
    S_AXI_awaddr = addr; S_AXI_wdata = data; S_AXI_wstrb = strb;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      if (c == aw_dly) S_AXI_awvalid = 1'b1;
      if (c == w_dly)  S_AXI_wvalid  = 1'b1;
      @(negedge clk);
      hs_aw = S_AXI_awvalid && S_AXI_awready;
      hs_w  = S_AXI_wvalid && S_AXI_wready;
      @(posedge clk); #1;
      if (hs_aw) begin aw_done = 1; S_AXI_awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1;  S_AXI_wvalid  = 1'b0; end
    end
    S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
    if (!(aw_done && w_done)) ok = 0;
    for (int c = 0; c < 40 && ok && !got; c++) begin
      S_AXI_bready = (c >= b_dly);
      @(negedge clk);
      if (S_AXI_bvalid && S_AXI_bready) begin got = 1; resp = S_AXI_bresp; end
      @(posedge clk); #1;
    end
    S_AXI_bready = 1'b0;
    if (!got) ok = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp, output bit ok);
    bit ar_done, hs_ar, got;
    ar_done = 0; got = 0; ok = 1; data = 'x; resp = 2'bxx;
    S_AXI_araddr = addr;
    for (int c = 0; c < 40 && !ar_done; c++) begin
      if (c == ar_dly) S_AXI_arvalid = 1'b1;
      @(negedge clk);
      hs_ar = S_AXI_arvalid && S_AXI_arready;
      @(posedge clk); #1;
      if (hs_ar) begin ar_done = 1; S_AXI_arvalid = 1'b0; end
    end
    S_AXI_arvalid = 1'b0;
    if (!ar_done) ok = 0;
    for (int c = 0; c < 40 && ok && !got; c++) begin
      S_AXI_rready = (c >= r_dly);
      @(negedge clk);
      if (S_AXI_rvalid && S_AXI_rready) begin got = 1; data = S_AXI_rdata; resp = S_AXI_rresp; end
      @(posedge clk); #1;
    end
    S_AXI_rready = 1'b0;
    if (!got) ok = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdat;
    bit          ok;

    rst = 1'b0;
    S_AXI_awaddr = '0; S_AXI_awprot = '0; S_AXI_awvalid = 1'b0;
    S_AXI_wdata = '0; S_AXI_wstrb = '0; S_AXI_wvalid = 1'b0; S_AXI_bready = 1'b0;
    S_AXI_araddr = '0; S_AXI_arprot = '0; S_AXI_arvalid = 1'b0; S_AXI_rready = 1'b0;

    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0, OKAY};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, OKAY};
    vecs[2]  = '{1'b1, 32'h00,   32'h01020304, 4'hF, 32'h0, OKAY};
    vecs[3]  = '{1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0, OOR_RESP};
    vecs[4]  = '{1'b0, 32'h00,   32'h0,        4'h0, RANGE_CHK ? 32'h01020304 : 32'hCAFEF00D, OKAY};
    vecs[5]  = '{1'b0, 32'h1000, 32'h0,        4'h0, RANGE_CHK ? 32'h0 : 32'hCAFEF00D, OOR_RESP};
    vecs[6]  = '{1'b1, 32'h24,   32'h00000055, 4'hF, 32'h0, OKAY};
    vecs[7]  = '{1'b1, 32'h24,   32'hFFFFFFFF, 4'h0, 32'h0, OKAY};
    vecs[8]  = '{1'b0, 32'h24,   32'h0,        4'h0, 32'h00000055, OKAY};
    vecs[9]  = '{1'b0, 32'h13,   32'h0,        4'h0, 32'hDEADBEEF, OKAY};
    vecs[10] = '{1'b1, 32'h28,   32'h00000000, 4'hF, 32'h0, OKAY};
    vecs[11] = '{1'b1, 32'h2B,   32'hAB00CD00, 4'hA, 32'h0, OKAY};
    vecs[12] = '{1'b0, 32'h28,   32'h0,        4'h0, 32'hAB00CD00, OKAY};

    // Reset state and ready release timing.
    repeat (2) @(negedge clk);
    check("rst_awready", S_AXI_awready, 0); check("rst_wready", S_AXI_wready, 0);
    check("rst_arready", S_AXI_arready, 0); check("rst_bvalid", S_AXI_bvalid, 0);
    check("rst_rvalid", S_AXI_rvalid, 0);   check("rst_bresp", S_AXI_bresp, 0);
    check("rst_rresp", S_AXI_rresp, 0);     check("rst_rdata", S_AXI_rdata, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rel_awready_before_edge", S_AXI_awready, 0);
    check("rel_arready_before_edge", S_AXI_arready, 0);
    @(negedge clk);
    check("rel_awready", S_AXI_awready, 1); check("rel_wready", S_AXI_wready, 1);
    check("rel_arready", S_AXI_arready, 1);
    @(posedge clk); #1;

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, resp, ok);
        check($sformatf("tbl%0d_wr_done", i), 32'(ok), 1);
        check($sformatf("tbl%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, 0, 0, rdat, resp, ok);
        check($sformatf("tbl%0d_rd_done", i), 32'(ok), 1);
        check($sformatf("tbl%0d_rdata", i), rdat, vecs[i].exp_data);
        check($sformatf("tbl%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end
      $display("vec %0d %s addr=%h done", i, vecs[i].is_wr ? "WR" : "RD", vecs[i].addr);
    end

    // W three cycles ahead of AW, then a single-byte update.
    S_AXI_wdata = 32'h11223344; S_AXI_wstrb = 4'hF; S_AXI_wvalid = 1'b1;
    @(negedge clk); check("wfirst_wready", S_AXI_wready, 1);
    @(posedge clk); #1 S_AXI_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wfirst_awready_idle", S_AXI_awready, 1);
      check("wfirst_wready_held", S_AXI_wready, 0);
      check("wfirst_no_bvalid", S_AXI_bvalid, 0);
      @(posedge clk); #1;
    end
    S_AXI_awaddr = 32'h20; S_AXI_awvalid = 1'b1;
    @(negedge clk); check("wfirst_aw_hs", S_AXI_awready, 1);
    @(posedge clk); #1 S_AXI_awvalid = 1'b0; S_AXI_bready = 1'b1;
    @(negedge clk); check("wfirst_bvalid", S_AXI_bvalid, 1); check("wfirst_bresp", S_AXI_bresp, 0);
    @(posedge clk); #1 S_AXI_bready = 1'b0;
    @(negedge clk); check("wfirst_bvalid_clear", S_AXI_bvalid, 0);
    @(posedge clk); #1;
    axi_write(32'h20, 32'h0000AA00, 4'h2, 0, 0, 0, resp, ok);
    check("partial_bresp", 32'(resp), 0);
    axi_read(32'h20, 0, 0, rdat, resp, ok);
    check("partial_rdata", rdat, 32'h1122AA44);
    $display("seq wfirst/partial done");

    // Response back-pressure: second write waits for the B handshake.
    S_AXI_awaddr = 32'h30; S_AXI_wdata = 32'hA5A5A5A5; S_AXI_wstrb = 4'hF;
    S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1;
    @(negedge clk); check("bp_aw_hs", S_AXI_awready, 1); check("bp_w_hs", S_AXI_wready, 1);
    @(posedge clk); #1;
    S_AXI_awaddr = 32'h34; S_AXI_wdata = 32'h5A5A5A5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_bvalid", S_AXI_bvalid, 1); check("bp_bresp", S_AXI_bresp, 0);
      check("bp_awready", S_AXI_awready, 0); check("bp_wready", S_AXI_wready, 0);
      @(posedge clk); #1;
    end
    S_AXI_bready = 1'b1;
    @(negedge clk); check("bp_bvalid_at_hs", S_AXI_bvalid, 1);
    @(posedge clk); #1 S_AXI_bready = 1'b0;
    @(negedge clk); check("bp2_awready", S_AXI_awready, 1); check("bp2_wready", S_AXI_wready, 1);
    @(posedge clk); #1 S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0; S_AXI_bready = 1'b1;
    @(negedge clk); check("bp2_bvalid", S_AXI_bvalid, 1);
    @(posedge clk); #1 S_AXI_bready = 1'b0;
    axi_read(32'h30, 0, 0, rdat, resp, ok); check("bp_rd1", rdat, 32'hA5A5A5A5);
    axi_read(32'h34, 0, 0, rdat, resp, ok); check("bp_rd2", rdat, 32'h5A5A5A5A);
    $display("seq backpressure done");

    // Same-edge read and write commit to one word: read sees old data.
    axi_write(32'h40, 32'h0, 4'hF, 0, 0, 0, resp, ok);
    S_AXI_awaddr = 32'h40; S_AXI_wdata = 32'h5; S_AXI_wstrb = 4'hF; S_AXI_araddr = 32'h40;
    S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1; S_AXI_arvalid = 1'b1;
    @(negedge clk); check("rbw_arready", S_AXI_arready, 1); check("rbw_awready", S_AXI_awready, 1);
    @(posedge clk); #1 S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0; S_AXI_arvalid = 1'b0; S_AXI_bready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rbw_rvalid_hold", S_AXI_rvalid, 1); check("rbw_rdata_old", S_AXI_rdata, 0);
      check("rbw_arready_low", S_AXI_arready, 0);
      @(posedge clk); #1 S_AXI_bready = 1'b0;
    end
    S_AXI_rready = 1'b1;
    @(negedge clk); check("rbw_rvalid_at_hs", S_AXI_rvalid, 1);
    @(posedge clk); #1 S_AXI_rready = 1'b0;
    @(negedge clk); check("rbw_rvalid_clear", S_AXI_rvalid, 0); check("rbw_arready_back", S_AXI_arready, 1);
    @(posedge clk); #1;
    axi_read(32'h40, 0, 0, rdat, resp, ok); check("rbw_new_data", rdat, 32'h5);
    $display("seq read-before-write done");

    // Reset while W is held and a read response is pending.
    S_AXI_wdata = 32'h77; S_AXI_wstrb = 4'hF; S_AXI_wvalid = 1'b1;
    S_AXI_araddr = 32'h10; S_AXI_arvalid = 1'b1;
    @(posedge clk); #1 S_AXI_wvalid = 1'b0; S_AXI_arvalid = 1'b0;
    @(negedge clk); check("mrst_rvalid_pending", S_AXI_rvalid, 1); check("mrst_w_held", S_AXI_wready, 0);
    #2 rst = 1'b0;
    #1;
    check("mrst_awready", S_AXI_awready, 0); check("mrst_wready", S_AXI_wready, 0);
    check("mrst_arready", S_AXI_arready, 0); check("mrst_bvalid", S_AXI_bvalid, 0);
    check("mrst_rvalid", S_AXI_rvalid, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); check("mrst_ready_first_edge", S_AXI_wready, 0);
    @(posedge clk); #1;
    S_AXI_awaddr = 32'h50; S_AXI_awvalid = 1'b1; S_AXI_bready = 1'b1; S_AXI_rready = 1'b1;
    @(negedge clk); check("mrst_awready_back", S_AXI_awready, 1); check("mrst_wready_back", S_AXI_wready, 1);
    @(posedge clk); #1 S_AXI_awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mrst_no_bvalid", S_AXI_bvalid, 0); check("mrst_no_rvalid", S_AXI_rvalid, 0);
      @(posedge clk); #1;
    end
    S_AXI_wdata = 32'h99; S_AXI_wvalid = 1'b1;
    @(negedge clk); check("mrst_w_hs", S_AXI_wready, 1);
    @(posedge clk); #1 S_AXI_wvalid = 1'b0;
    @(negedge clk); check("mrst_bvalid_new", S_AXI_bvalid, 1);
    @(posedge clk); #1 S_AXI_bready = 1'b0; S_AXI_rready = 1'b0;
    axi_read(32'h50, 0, 0, rdat, resp, ok); check("mrst_rdata", rdat, 32'h99);
    $display("seq mid-reset done");

    // Randomized traffic in words 128..159 against the reference model.
    for (int w = 128; w < 160; w++) begin
      model[w] = $urandom;
      axi_write(32'(w * 4), model[w], 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), 0, resp, ok);
      check("rnd_init_done", 32'(ok), 1);
    end
    for (int n = 0; n < 200; n++) begin
      int          word;
      logic [31:0] addr, data;
      logic [3:0]  strb;
      bit          oor;
      word = $urandom_range(128, 159);
      addr = 32'(word * 4) + 32'($urandom_range(0, 3));
      oor  = ($urandom_range(0, 7) == 0);
      if (oor) addr = addr | (32'h1 << $urandom_range(12, 31));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp, ok);
        if (!(RANGE_CHK && oor))
          for (int b = 0; b < 4; b++) if (strb[b]) model[word][b*8 +: 8] = data[b*8 +: 8];
        check("rnd_wr_done", 32'(ok), 1);
        check("rnd_bresp", 32'(resp), (RANGE_CHK && oor) ? 32'(SLVERR) : 32'(OKAY));
        $display("rnd %0d WR addr=%h data=%h strb=%h resp=%0d", n, addr, data, strb, resp);
      end else begin
        axi_read(addr, $urandom_range(0, 3), $urandom_range(0, 3), rdat, resp, ok);
        check("rnd_rd_done", 32'(ok), 1);
        check("rnd_rdata", rdat, (RANGE_CHK && oor) ? 32'h0 : model[word]);
        check("rnd_rresp", 32'(resp), (RANGE_CHK && oor) ? 32'(SLVERR) : 32'(OKAY));
        $display("rnd %0d RD addr=%h data=%h resp=%0d", n, addr, rdat, resp);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
